// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction cache geometry, address split, frame layout and miss FSM states.
// The geometry is fixed here so every user sees the same tag/index widths.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int SETS   = 16;
    localparam int IIDX_W = $clog2(SETS);
    localparam int ITAG_W = WORD_W - IIDX_W - 2;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        off;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [WORD_W-1:0] data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        FETCH
    } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: combinational read at ridx, single write port.
// Read is zero-latency, writes land on the clock edge; no backpressure, always accepts a write.
// Only the valid bits are reset; tag/data are qualified by valid so they need no reset.
module icache_frame_array
    import cpu_types_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic [IIDX_W-1:0]   ridx,
    output icache_frame_t       rframe,
    input  logic                wen,
    input  logic [IIDX_W-1:0]   widx,
    input  icache_frame_t       wframe
);

    logic [SETS-1:0]   valid_q;
    logic [ITAG_W-1:0] tag_q  [SETS];
    logic [WORD_W-1:0] data_q [SETS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
        end else if (wen) begin
            valid_q[widx] <= wframe.valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (wen) begin
            tag_q[widx]  <= wframe.tag;
            data_q[widx] <= wframe.data;
        end
    end

    always_comb begin
        rframe       = '0;
        rframe.valid = valid_q[ridx];
        rframe.tag   = tag_q[ridx];
        rframe.data  = data_q[ridx];
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-block instruction cache between fetch and the memory controller.
// Hit: 0 cycles. Miss: detect cycle + iwait cycles + fill cycle, hit on the following cycle.
// Memory backpressure via iwait holds FETCH with a stable request; fetch sees ihit low meanwhile.
module icache
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    icachef_t          req;
    icache_state_t     state, state_n;
    logic [WORD_W-3:0] miss_word;
    icache_frame_t     rframe;
    icache_frame_t     wframe;
    logic              hit;
    logic              fill;
    logic              fill_en;
    logic              unused_off;

    assign req        = imemaddr;
    assign unused_off = ^req.off;

    icache_frame_array u_frames (
        .CLK    (CLK),
        .RST    (RST),
        .ridx   (req.idx),
        .rframe (rframe),
        .wen    (fill_en),
        .widx   (miss_word[IIDX_W-1:0]),
        .wframe (wframe)
    );

    assign hit      = imemREN & rframe.valid & (rframe.tag == req.tag) & (state == IDLE);
    assign ihit     = hit;
    assign imemload = rframe.data;

    // A reset landing on the fill cycle must not commit the in-flight word.
    assign fill_en  = fill & ~RST;

    always_comb begin
        wframe       = '0;
        wframe.valid = 1'b1;
        wframe.tag   = miss_word[WORD_W-3:IIDX_W];
        wframe.data  = iload;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            miss_word <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && imemREN && !hit) begin
                miss_word <= imemaddr[31:2];
            end
        end
    end

    always_comb begin
        state_n = state;
        iREN    = 1'b0;
        iaddr   = '0;
        fill    = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN && !hit) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_word, 2'b00};
                if (!iwait) begin
                    fill    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios then randomized accesses against a
// behavioural model (array of frames filled from a deterministic memory function).
module tb_icache;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks   = 0;
    int failures = 0;

    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_data  [16];

    always #5 CLK = ~CLK;

    icache dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        if (w == 32'h10) return 32'h8C220004;
        return (w * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic int midx(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    function automatic logic [31:0] mtag(input logic [31:0] a);
        return a >> 6;
    endfunction

    function automatic bit exp_hit(input logic [31:0] a);
        return m_valid[midx(a)] && (m_tag[midx(a)] == mtag(a));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic idle_cycle();
        imemREN  = 1'b0;
        imemaddr = $urandom;
        iwait    = 1'b1;
        @(negedge CLK);
        chk("idle_ihit", ihit, 0);
        chk("idle_iren", iREN, 0);
        tick();
    endtask

    // One fetch request to a; on a miss, memory answers after 'waits' busy cycles while the
    // pipeline presents 'redirect' (and optionally drops imemREN).
    task automatic access(input logic [31:0] a, input int waits,
                          input logic [31:0] redirect, input bit drop_ren);
        bit h;
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        @(negedge CLK);
        h = exp_hit(a);
        chk("lookup_ihit", ihit, h);
        chk("lookup_iren", iREN, 0);
        if (h) begin
            chk("hit_load", imemload, m_data[midx(a)]);
            tick();
            return;
        end
        tick();
        for (int k = 0; k <= waits; k++) begin
            imemaddr = redirect;
            imemREN  = !drop_ren;
            iwait    = (k < waits);
            iload    = (k < waits) ? $urandom : mem_word(a);
            @(negedge CLK);
            chk("fetch_iren", iREN, 1);
            chk("fetch_iaddr", iaddr, {a[31:2], 2'b00});
            chk("fetch_ihit", ihit, 0);
            tick();
        end
        m_valid[midx(a)] = 1'b1;
        m_tag[midx(a)]   = mtag(a);
        m_data[midx(a)]  = mem_word(a);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] redir;
        int          r;

        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
        clear_model();
        tick(); tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_ihit", ihit, 0);
        chk("rst_iren", iREN, 0);
        chk("rst_iaddr", iaddr, 0);
        tick();

        // Cold miss then warm hit on 0x40
        access(32'h40, 2, 32'h40, 1'b0);
        imemREN = 1'b1; imemaddr = 32'h40;
        @(negedge CLK);
        chk("warm_ihit", ihit, 1);
        chk("warm_load", imemload, 32'h8C220004);
        chk("warm_iren", iREN, 0);
        tick();

        // Conflict: 0x80 evicts 0x40
        access(32'h80, 1, 32'h80, 1'b0);
        access(32'h80, 0, 32'h80, 1'b0);
        access(32'h40, 0, 32'h40, 1'b0);
        access(32'h40, 0, 32'h40, 1'b0);

        // Redirect mid-miss: 0x100 still fills, then 0x200 misses
        access(32'h100, 2, 32'h200, 1'b0);
        access(32'h100, 0, 32'h100, 1'b0);
        access(32'h200, 1, 32'h200, 1'b0);
        access(32'h200, 0, 32'h200, 1'b0);

        // imemREN dropping during FETCH: fill completes, no new miss
        access(32'h1C, 2, 32'h1C, 1'b1);
        idle_cycle();
        access(32'h1C, 0, 32'h1C, 1'b0);

        // Offset ignore
        access(32'h44, 1, 32'h44, 1'b0);
        access(32'h47, 0, 32'h47, 1'b0);

        // Reset mid-miss
        imemREN = 1'b1; imemaddr = 32'h3C0; iwait = 1'b1;
        @(negedge CLK);
        chk("rstm_lookup", ihit, 0);
        tick();
        @(negedge CLK);
        chk("rstm_fetch1", iREN, 1);
        tick();
        RST = 1'b1; iwait = 1'b0; iload = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("rstm_fetch2", iREN, 1);
        tick();
        RST = 1'b0; imemREN = 1'b0;
        clear_model();
        @(negedge CLK);
        chk("rstm_iren", iREN, 0);
        chk("rstm_iaddr", iaddr, 0);
        tick();
        access(32'h40, 0, 32'h40, 1'b0);
        access(32'h44, 1, 32'h44, 1'b0);
        access(32'h3C0, 0, 32'h3C0, 1'b0);
        access(32'h3C0, 0, 32'h3C0, 1'b0);

        // Randomized traffic over a small address space to mix hits and conflicts
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                idle_cycle();
            end else begin
                a = $urandom_range(0, 32'h3FF);
                if (r == 1) a[31:24] = 8'($urandom);
                redir = (r == 2) ? $urandom : a;
                access(a, $urandom_range(0, 3), redir, r == 3);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
